// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, ALU/mux selects.
// Purely declarative; the controller and its opcode decoder import this package.
package multicycle_control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC_R = 4'd6,
        ST_EXEC_I = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    // Exactly one bit is set for any opcode value.
    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic branch;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier producing a one-hot instruction class.
// Zero latency, no flow control; anything unrecognised is classed illegal.
module opcode_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_R:      o_class.r       = 1'b1;
            OP_I:      o_class.i       = 1'b1;
            OP_LOAD:   o_class.load    = 1'b1;
            OP_STORE:  o_class.store   = 1'b1;
            OP_BRANCH: o_class.branch  = 1'b1;
            default:   o_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle RISC datapath; 2-5 cycles per instruction.
// Memory states stall on mem_ready with outputs held; rst forces all outputs low.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       memreg,
    output logic [1:0] alusrc_a,
    output logic [1:0] alusrc_b,
    output logic [1:0] aluop,
    output logic       pcsrc,
    output logic       instr_done,
    output logic       illegal
);

    state_t    r_state;
    state_t    w_next;
    op_class_t w_class;

    opcode_decode u_opcode_decode (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_next;
    end

    // Opcode only steers the machine in DECODE and MEMADR.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_class.r)                        w_next = ST_EXEC_R;
                else if (w_class.i)                   w_next = ST_EXEC_I;
                else if (w_class.load || w_class.store) w_next = ST_MEMADR;
                else if (w_class.branch)              w_next = ST_BRANCH;
                else                                  w_next = ST_FETCH;
            end
            ST_MEMADR: w_next = w_class.store ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (mem_ready) w_next = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) w_next = ST_FETCH;
            ST_EXEC_R: w_next = ST_ALUWB;
            ST_EXEC_I: w_next = ST_ALUWB;
            default:   w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        memreg     = 1'b0;
        alusrc_a   = SRCA_PC;
        alusrc_b   = SRCB_RS2;
        aluop      = ALUOP_ADD;
        pcsrc      = PCSRC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    alusrc_b = SRCB_FOUR;
                    ir_we    = mem_ready;
                    pc_we    = mem_ready;
                end
                ST_DECODE: begin
                    alusrc_a = SRCA_OLDPC;
                    alusrc_b = SRCB_IMM;
                    illegal  = w_class.illegal;
                end
                ST_MEMADR: begin
                    alusrc_a = SRCA_RS1;
                    alusrc_b = SRCB_IMM;
                end
                ST_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                ST_MEMWB: begin
                    reg_write  = 1'b1;
                    memreg     = 1'b1;
                    instr_done = 1'b1;
                end
                ST_MEMWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                ST_EXEC_R: begin
                    alusrc_a = SRCA_RS1;
                    alusrc_b = SRCB_RS2;
                    aluop    = ALUOP_FUNCT;
                end
                ST_EXEC_I: begin
                    alusrc_a = SRCA_RS1;
                    alusrc_b = SRCB_IMM;
                    aluop    = ALUOP_FUNCT;
                end
                ST_ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    alusrc_a   = SRCA_RS1;
                    alusrc_b   = SRCB_RS2;
                    aluop      = ALUOP_SUB;
                    pcsrc      = PCSRC_ALUOUT;
                    pc_we      = zero;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port opcode, input, 7 bits: instruction register bits [6:0], valid from DECODE onward.
REQ-004 SHALL have port zero, input, 1 bit: ALU equality flag, sampled in BRANCH.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current read or write this cycle.
REQ-006 SHALL have ports pc_we, ir_we, mem_read, mem_write, iord, reg_write, memreg, output, 1 bit each: datapath enables and selects; iord=1 selects ALU-out as the memory address.
REQ-007 SHALL have port alusrc_a, output, 2 bits: 00 PC, 01 old_pc, 10 rs1.
REQ-008 SHALL have port alusrc_b, output, 2 bits: 00 rs2, 01 constant 4, 10 immediate.
REQ-009 SHALL have port aluop, output, 2 bits: 00 add, 01 subtract/compare, 10 funct-decoded.
REQ-010 SHALL have port pcsrc, output, 1 bit: 0 ALU result, 1 ALU-out register (branch target).
REQ-011 SHALL have ports instr_done and illegal, output, 1 bit each: single-cycle completion and fault pulses.

Function
REQ-012 SHALL implement the Moore FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH; outputs SHALL be 0 unless listed below.
REQ-013 In FETCH: mem_read=1, alusrc_a=00, alusrc_b=01, aluop=00; ir_we=pc_we=mem_ready; stay until mem_ready=1, then go to DECODE.
REQ-014 In DECODE: alusrc_a=01, alusrc_b=10, aluop=00 (branch target to ALU-out); next state by opcode: 0110011 EXEC_R, 0010011 EXEC_I, 0000011/0100011 MEMADR, 1100011 BRANCH, any other FETCH with illegal=1.
REQ-015 In MEMADR: alusrc_a=10, alusrc_b=10, aluop=00; next state MEMRD for load, MEMWR for store.
REQ-016 In MEMRD: mem_read=1, iord=1; hold until mem_ready, then go to MEMWB.
REQ-017 In MEMWB: reg_write=1, memreg=1, instr_done=1; next state FETCH.
REQ-018 In MEMWR: mem_write=1, iord=1; hold until mem_ready; in the mem_ready cycle instr_done=1; then go to FETCH.
REQ-019 In EXEC_R: alusrc_a=10, alusrc_b=00, aluop=10. In EXEC_I: alusrc_a=10, alusrc_b=10, aluop=10. Both SHALL go to ALUWB.
REQ-020 In ALUWB: reg_write=1, memreg=0, instr_done=1; next state FETCH.
REQ-021 In BRANCH: alusrc_a=10, alusrc_b=00, aluop=01, pcsrc=1, pc_we=zero, instr_done=1; next state FETCH.
REQ-022 SHALL sample opcode only in DECODE and MEMADR; opcode changes in other states SHALL have no effect.
REQ-023 Latency with mem_ready held at 1 SHALL be: R/I 4 cycles, load 5, store 4, branch 3, illegal 2.
REQ-024 Each memory-wait cycle SHALL add exactly one cycle, with outputs held stable during the wait.
REQ-025 SHALL never assert mem_read and mem_write together, and SHALL never assert reg_write in the same cycle as mem_write.

Reset
REQ-026 While rst=1 at a clock edge, the next state SHALL be FETCH.
REQ-027 While rst=1, all outputs SHALL be forced to 0, overriding state decode.
REQ-028 Reset asserted in any state, including a memory wait, SHALL abort the instruction with no reg_write or pc_we.
REQ-029 The first cycle after rst deasserts SHALL be FETCH with mem_read=1.

Structure
REQ-030 A shared package SHALL hold: opcode constants, the state enumeration (4-bit encoding), aluop codes, alusrc_a and alusrc_b codes, and the pcsrc code.
REQ-031 One sub-module, opcode_decode, SHALL map opcode to a one-hot class {R, I, LOAD, STORE, BRANCH, ILLEGAL}; the FSM and output decode SHALL live in multicycle_control.

Verification
REQ-032 Reset then opcode=0110011 with mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALUWB; reg_write=1 only in cycle 4, instr_done pulses once.
REQ-033 Load (0000011) with mem_ready low for 3 cycles in MEMRD -> mem_read and iord held 4 cycles, total 8 cycles, reg_write with memreg=1 once.
REQ-034 Branch (1100011) with zero=1 -> pc_we=1 and pcsrc=1 in cycle 3; repeat with zero=0 -> pc_we=0 in cycle 3.
REQ-035 opcode=1111111 -> illegal=1 in DECODE, FETCH next cycle, no reg_write, mem_write or instr_done.
REQ-036 rst asserted during a MEMWR wait -> mem_write=0 the same cycle, FETCH after release, no instr_done.
REQ-037 Randomised opcode and mem_ready for 10k cycles -> REQ-025 holds, and exactly one instr_done or illegal occurs per FETCH-to-DECODE transition.
